// File: rtl/fpu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_arbiter_if
//  Purpose  : Client-side request/response bundle of the shared-FPU arbiter.
//             Requests are packed per requester: requester i owns slice
//             [i*PRECISION +: PRECISION] of req_a/req_b and [i*2 +: 2] of
//             req_op.
//  Modports : master - client side (drives requests, receives responses)
//             slave  - arbiter side
//  Revision : 1.0 - initial release
// ============================================================================
interface fpu_arbiter_if #(
    parameter int PRECISION = 32,
    parameter int NUM_REQ   = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*PRECISION-1:0] req_a;
    logic [NUM_REQ*PRECISION-1:0] req_b;
    logic [NUM_REQ*2-1:0]         req_op;

    logic                         rsp_valid;
    logic [ID_W-1:0]              rsp_id;
    logic [PRECISION-1:0]         rsp_result;
    logic                         rsp_error;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_error
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_error
    );
endinterface
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one FPU among NUM_REQ
//             requesters. Latches the winner's operands, holds fpu_start high
//             for START_CYCLES cycles, waits for fpu_done and returns the
//             result tagged with the requester index.
//  Ports    : clk, reset_n (async, active low)
//             bus        - fpu_arbiter_if.slave request/response bundle
//             fpu_a/b/op - registered operands to the FPU
//             fpu_start  - drives the FPU Reset input (high = load operands)
//             fpu_result, fpu_done - FPU outputs (done is a level)
//             busy       - high whenever the sequencer is not idle
//  Options  : `define FPU_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT
//             cycles with rsp_error=1 and rsp_result=0.
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_arbiter #(
    parameter int PRECISION    = 32,
    parameter int NUM_REQ      = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  wire                  clk,
    input  wire                  reset_n,
    fpu_arbiter_if.slave         bus,
    output logic [PRECISION-1:0] fpu_a,
    output logic [PRECISION-1:0] fpu_b,
    output logic [1:0]           fpu_op,
    output logic                 fpu_start,
    input  wire [PRECISION-1:0]  fpu_result,
    input  wire                  fpu_done,
    output logic                 busy
);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [ID_W-1:0]  C_LAST_ID    = ID_W'(NUM_REQ - 1);
`ifdef FPU_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_wait_armed, w_wait_armed_nxt;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_id;
    logic [PRECISION-1:0] r_fpu_a, r_fpu_b, r_result;
    logic [1:0]           r_fpu_op;
    logic                 w_capture, w_res_load, w_timeout;
    logic [ID_W-1:0]      w_grant;
    logic                 w_found;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic [ID_W-1:0]      w_ptr_nxt;
`ifdef FPU_ARB_TIMEOUT_EN
    logic                 r_error;
`endif

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int offs);
        int s;
        s = (int'(base) + offs) % NUM_REQ;
        return ID_W'(s);
    endfunction

    // Scan downward so the smallest offset from rr_ptr is the last writer.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[rr_idx(r_rr_ptr, k)]) begin
                w_grant = rr_idx(r_rr_ptr, k);
                w_found = 1'b1;
            end
        end
    end

    assign w_grant_oh = NUM_REQ'(1) << w_grant;
    assign w_ptr_nxt  = (r_id == C_LAST_ID) ? '0 : r_id + ID_W'(1);

    // Ready is gated by reset_n so nothing is accepted while reset is held.
    assign bus.req_ready = (r_state == S_IDLE && w_found && reset_n) ? w_grant_oh : '0;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_wait_armed_nxt = r_wait_armed;
        w_capture        = 1'b0;
        w_res_load       = 1'b0;
        w_timeout        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == C_START_LAST) begin
                    w_cnt_nxt        = '0;
                    w_wait_armed_nxt = 1'b0;
                    w_state_nxt      = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // Done may still be high from the previous operation during
                // the first WAIT cycle; only sample it once armed.
                w_wait_armed_nxt = 1'b1;
                if (r_wait_armed && fpu_done) begin
                    w_res_load  = 1'b1;
                    w_state_nxt = S_RESP;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (r_cnt == C_TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wait_armed <= 1'b0;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_fpu_a      <= '0;
            r_fpu_b      <= '0;
            r_fpu_op     <= 2'b00;
            r_result     <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
            r_error      <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wait_armed <= w_wait_armed_nxt;
            if (w_capture) begin
                r_fpu_a  <= bus.req_a[w_grant*PRECISION +: PRECISION];
                r_fpu_b  <= bus.req_b[w_grant*PRECISION +: PRECISION];
                r_fpu_op <= bus.req_op[w_grant*2 +: 2];
                r_id     <= w_grant;
            end
            if (w_res_load) begin
                r_result <= fpu_result;
            end
`ifdef FPU_ARB_TIMEOUT_EN
            if (w_res_load) begin
                r_error <= 1'b0;
            end
            if (w_timeout) begin
                r_result <= '0;
                r_error  <= 1'b1;
            end
`endif
            if (r_state == S_RESP) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign fpu_a          = r_fpu_a;
    assign fpu_b          = r_fpu_b;
    assign fpu_op         = r_fpu_op;
    assign fpu_start      = (r_state == S_START);
    assign busy           = (r_state != S_IDLE);
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;
`ifdef FPU_ARB_TIMEOUT_EN
    assign bus.rsp_error  = (r_state == S_RESP) & r_error;
`else
    assign bus.rsp_error  = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_arbiter
//  Purpose  : Self-checking bench for fpu_arbiter with a behavioural FPU and
//             a cycle-timing model of the arbiter's externally visible rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_arbiter;
    localparam int P        = 32;
    localparam int N        = 4;
    localparam int S        = 2;
    localparam int TO       = 64;
    localparam int DONE_DLY = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [P-1:0] fpu_a, fpu_b, fpu_result;
    logic [1:0]   fpu_op;
    logic         fpu_start, fpu_done, busy;

    fpu_arbiter_if #(.PRECISION(P), .NUM_REQ(N)) bus ();

    fpu_arbiter #(.PRECISION(P), .NUM_REQ(N), .START_CYCLES(S), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_op     (fpu_op),
        .fpu_start  (fpu_start),
        .fpu_result (fpu_result),
        .fpu_done   (fpu_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    // Stand-in FPU: the three float cases used below, integer ops otherwise.
    function automatic logic [P-1:0] fpu_calc(input logic [P-1:0] a, input logic [P-1:0] b,
                                              input logic [1:0] op);
        if (a == 32'h3FC00000 && b == 32'h3FC00000 && op == 2'b00) return 32'h40400000;
        if (a == 32'h40000000 && b == 32'h40800000 && op == 2'b10) return 32'h41000000;
        if (a == 32'h3F800000 && b == 32'h40800000 && op == 2'b11) return 32'h3E800000;
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return a ^ b;
        endcase
    endfunction

    // ---------------- FPU behavioural model ----------------
    bit force_done = 1'b0;
    bit never_done = 1'b0;
    initial begin
        int  cd;
        bit  mdone;
        bit  prev_start;
        cd = -1; mdone = 1'b0; prev_start = 1'b0;
        fpu_done = 1'b0;
        fpu_result = '0;
        forever begin
            @(posedge clk); #1;
            if (fpu_start) begin
                mdone = 1'b0;
                cd    = -1;
            end else if (prev_start) begin
                cd = DONE_DLY;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) mdone = 1'b1;
            end
            prev_start = fpu_start;
            fpu_done   = force_done | (mdone & ~never_done);
            fpu_result = fpu_calc(fpu_a, fpu_b, fpu_op);
        end
    end

    // ---------------- arbiter model and per-cycle compare ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           grant_log[$];
    int           rsp_id_q[$];
    logic [P-1:0] rsp_res_q[$];
    int           rsp_err_q[$];
    int           rsp_lat_q[$];
    int           start_hi = 0;

    initial begin
        int           m_ptr, m_hs, m_rsp, m_id, win;
        bit           m_out, m_err, after, e_rv;
        logic [P-1:0] m_a, m_b, m_exp, m_res;
        logic [1:0]   m_op;
        logic [N-1:0] v, e_ready;
        m_ptr = 0; m_hs = 0; m_rsp = -1; m_id = 0; m_out = 0; m_err = 0;
        m_a = '0; m_b = '0; m_op = '0; m_exp = '0; m_res = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_ready", bus.req_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_start", fpu_start, 0);
                chk("rst_rsp_valid", bus.rsp_valid, 0);
                chk("rst_rsp_error", bus.rsp_error, 0);
                chk("rst_rsp_id", bus.rsp_id, 0);
                chk("rst_rsp_result", bus.rsp_result, 0);
                chk("rst_fpu_ab", {fpu_a, fpu_b}, 0);
                chk("rst_fpu_op", fpu_op, 0);
                m_ptr = 0; m_out = 0; m_rsp = -1;
            end else begin
                v = bus.req_valid;
                win = -1;
                if (!m_out)
                    for (int k = 0; k < N; k++)
                        if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                e_ready = '0;
                if (win >= 0) e_ready[win] = 1'b1;
                after = m_out && (cyc > m_hs);
                chk("ready", bus.req_ready, e_ready);
                chk("busy", busy, after);
                chk("fpu_start", fpu_start, m_out && cyc >= m_hs + 1 && cyc <= m_hs + S);
                if (after) begin
                    chk("fpu_a_hold", fpu_a, m_a);
                    chk("fpu_b_hold", fpu_b, m_b);
                    chk("fpu_op_hold", fpu_op, m_op);
                end
                e_rv = m_out && (m_rsp == cyc);
                chk("rsp_valid", bus.rsp_valid, e_rv);
                if (e_rv) begin
                    chk("rsp_id", bus.rsp_id, m_id);
                    chk("rsp_result", bus.rsp_result, m_res);
                    chk("rsp_error", bus.rsp_error, m_err);
                    rsp_id_q.push_back(int'(bus.rsp_id));
                    rsp_res_q.push_back(bus.rsp_result);
                    rsp_err_q.push_back(int'(bus.rsp_error));
                    rsp_lat_q.push_back(cyc - m_hs);
                end else begin
                    chk("rsp_error_idle", bus.rsp_error, 0);
                end
                if (fpu_start) start_hi++;
                // Done counts only from the second cycle after start falls.
                if (m_out && m_rsp < 0) begin
                    if (cyc >= m_hs + S + 2 && fpu_done) begin
                        m_rsp = cyc + 1; m_err = 0; m_res = m_exp;
                    end
`ifdef FPU_ARB_TIMEOUT_EN
                    else if (cyc == m_hs + S + TO) begin
                        m_rsp = cyc + 1; m_err = 1; m_res = '0;
                    end
`endif
                end
                if (e_rv) begin
                    m_out = 0;
                    m_ptr = (m_id + 1) % N;
                end else if (!m_out && win >= 0) begin
                    m_out = 1; m_hs = cyc; m_rsp = -1; m_id = win;
                    m_a   = bus.req_a[win*P +: P];
                    m_b   = bus.req_b[win*P +: P];
                    m_op  = bus.req_op[win*2 +: 2];
                    m_exp = fpu_calc(m_a, m_b, m_op);
                    grant_log.push_back(win);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit hold = 1'b0;

    // One cycle; a requester that was accepted drops valid and scrambles its
    // operands unless hold is set.
    task automatic step();
        logic [N-1:0] m;
        @(negedge clk);
        m = bus.req_ready & bus.req_valid;
        @(posedge clk); #1;
        if (!hold)
            for (int i = 0; i < N; i++)
                if (m[i]) begin
                    bus.req_valid[i]        = 1'b0;
                    bus.req_a[i*P +: P]     = 32'hDEAD0000 | i;
                    bus.req_b[i*P +: P]     = 32'hBEEF0000 | i;
                    bus.req_op[i*2 +: 2]    = 2'b11;
                end
    endtask

    task automatic post(input int i, input logic [P-1:0] a, input logic [P-1:0] b,
                        input logic [1:0] op);
        bus.req_a[i*P +: P]  = a;
        bus.req_b[i*P +: P]  = b;
        bus.req_op[i*2 +: 2] = op;
        bus.req_valid[i]     = 1'b1;
    endtask

    task automatic wait_rsp(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (rsp_id_q.size() < n && t < budget) begin
            step();
            t++;
        end
        chk(name, rsp_id_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            step();
            t++;
        end
        chk("wait_idle", busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rb, gb, s0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        #1;
        bus.req_valid = 4'b1111;
        #1;
        chk("t0_ready_in_reset", bus.req_ready, 0);
        chk("t0_busy_in_reset", busy, 0);
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Simultaneous requests 1 and 3 straight after reset.
        rb = rsp_id_q.size(); gb = grant_log.size();
        post(1, 32'h40000000, 32'h40800000, 2'b10);
        post(3, 32'h3F800000, 32'h40800000, 2'b11);
        wait_rsp(rb + 2, 200, "t2_two_rsps");
        if (rsp_id_q.size() >= rb + 2) begin
            chk("t2_grant_first", grant_log[gb], 1);
            chk("t2_grant_second", grant_log[gb+1], 3);
            chk("t2_id_first", rsp_id_q[rb], 1);
            chk("t2_res_mul", rsp_res_q[rb], 32'h41000000);
            chk("t2_id_second", rsp_id_q[rb+1], 3);
            chk("t2_res_div", rsp_res_q[rb+1], 32'h3E800000);
        end
        wait_idle(50);

        // Fairness: all four held valid continuously.
        gb = grant_log.size();
        hold = 1'b1;
        for (int i = 0; i < N; i++) post(i, 32'h100 + i, 32'h10 + i, 2'(i));
        for (int t = 0; t < 300 && grant_log.size() < gb + 5; t++) step();
        hold = 1'b0;
        bus.req_valid = '0;
        chk("t4_grants", grant_log.size(), gb + 5);
        if (grant_log.size() >= gb + 5)
            for (int k = 0; k < 5; k++) chk("t4_grant_order", grant_log[gb+k], k % N);
        wait_idle(50);

        // Single request from requester 0.
        rb = rsp_id_q.size(); s0 = start_hi;
        post(0, 32'h3FC00000, 32'h3FC00000, 2'b00);
        wait_rsp(rb + 1, 100, "t1_rsp");
        repeat (4) step();
        chk("t1_one_pulse", rsp_id_q.size(), rb + 1);
        chk("t1_start_cycles", start_hi - s0, 2);
        if (rsp_id_q.size() > rb) begin
            chk("t1_id", rsp_id_q[rb], 0);
            chk("t1_res", rsp_res_q[rb], 32'h40400000);
            chk("t1_err", rsp_err_q[rb], 0);
        end

        // Done held high throughout: earliest possible response.
        rb = rsp_id_q.size();
        force_done = 1'b1;
        post(2, 32'h1, 32'h2, 2'b00);
        wait_rsp(rb + 1, 50, "t5_rsp");
        force_done = 1'b0;
        if (rsp_id_q.size() > rb) begin
            chk("t5_latency", rsp_lat_q[rb], S + 3);
            chk("t5_id", rsp_id_q[rb], 2);
            chk("t5_res", rsp_res_q[rb], 32'h3);
        end
        wait_idle(50);

        // Reset while in WAIT.
        post(3, 32'h5, 32'h6, 2'b01);
        for (int t = 0; t < 40 && !(busy && !fpu_start); t++) step();
        step();
        chk("t6_in_wait", busy && !fpu_start, 1);
        rb = rsp_id_q.size(); gb = grant_log.size();
        post(1, 32'h9, 32'h4, 2'b01);
        post(3, 32'h7, 32'h3, 2'b10);
        reset_n = 1'b0;
        #1;
        chk("t6_busy_now", busy, 0);
        chk("t6_start_now", fpu_start, 0);
        chk("t6_fpu_a_now", fpu_a, 0);
        chk("t6_ready_now", bus.req_ready, 0);
        chk("t6_rsp_valid_now", bus.rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_rsp(rb + 2, 200, "t6_rsps");
        if (rsp_id_q.size() >= rb + 2) begin
            chk("t6_grant_after_reset", grant_log[gb], 1);
            chk("t6_first_id", rsp_id_q[rb], 1);
            chk("t6_first_res", rsp_res_q[rb], 32'h5);
            chk("t6_second_id", rsp_id_q[rb+1], 3);
            chk("t6_second_res", rsp_res_q[rb+1], 32'h15);
        end
        wait_idle(50);

`ifdef FPU_ARB_TIMEOUT_EN
        // FPU never completes.
        rb = rsp_id_q.size();
        never_done = 1'b1;
        post(0, 32'h7, 32'h8, 2'b00);
        wait_rsp(rb + 1, 200, "t7_rsp");
        never_done = 1'b0;
        if (rsp_id_q.size() > rb) begin
            chk("t7_err", rsp_err_q[rb], 1);
            chk("t7_res", rsp_res_q[rb], 0);
            chk("t7_latency", rsp_lat_q[rb], S + TO + 1);
        end
        wait_idle(50);
`endif

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/fpu_arbiter.md
# fpu_arbiter

Round-robin arbiter and sequencer that shares one `FPU` instance among `NUM_REQ` requesters. It accepts operand/operation requests over a valid/ready handshake and latches the winner's operands. It then drives the FPU start protocol (start held high to load operands, released to compute) and waits for `Done`. Finally it returns the result tagged with the requester ID. It sits between client blocks and the `FPU`, whose `Reset` input is connected to `Fpu_Start`.

## Interface
- `PRECISION`, 32: operand/result width in bits.
- `NUM_REQ`, 4: number of requesters, at least 2.
- `START_CYCLES`, 2: cycles `Fpu_Start` is held high per operation, at least 1.
- `TIMEOUT`, 64: WAIT-state cycle limit; used only with `FPU_ARB_TIMEOUT_EN`.
- `ID_W`: derived as `$clog2(NUM_REQ)`, not overridable.

Ports:
- `Clk` in 1: single clock; all state updates on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Req_Valid` in NUM_REQ: per-requester request valid.
- `Req_Ready` out NUM_REQ: per-requester accept; at most one bit high.
- `Req_A` in NUM_REQ*PRECISION: operand A; requester i is slice `[i*PRECISION +: PRECISION]`.
- `Req_B` in NUM_REQ*PRECISION: operand B, same packing as `Req_A`.
- `Req_Op` in NUM_REQ*2: operation, same encoding as FPU: 00 add, 01 sub, 10 mul, 11 div.
- `Rsp_Valid` out 1: one-cycle response pulse; no backpressure.
- `Rsp_Id` out ID_W: index of the requester being answered.
- `Rsp_Result` out PRECISION: FPU result.
- `Rsp_Error` out 1: timeout flag.
- `Fpu_A`, `Fpu_B` out PRECISION: registered operands to FPU.
- `Fpu_Op` out 2: registered operation to FPU.
- `Fpu_Start` out 1: drives the FPU `Reset` input; high loads operands, low lets the FPU compute.
- `Fpu_Result` in PRECISION: FPU result.
- `Fpu_Done` in 1: FPU completion, level signal.
- `Busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, START, WAIT, RESP.
- **IDLE**
  - Grant = first i with `Req_Valid[i]`=1, searching from `rr_ptr` upward with wrap.
  - `Req_Ready[grant]`=1, combinational from `Req_Valid` and `rr_ptr`.
  - On the handshake edge: latch the granted slice into `Fpu_A`/`Fpu_B`/`Fpu_Op`, latch grant into an ID register, clear the counter, go to START.
  - With no valid request, stay in IDLE.
- **START**
  - `Fpu_Start`=1 for exactly `START_CYCLES` cycles, then go to WAIT with the counter cleared.
- **WAIT**
  - `Fpu_Start`=0.
  - `Fpu_Done` is ignored in the first WAIT cycle, because the FPU's Done may not yet have cleared.
  - From the second WAIT cycle on, `Fpu_Done`=1 latches `Fpu_Result` into the result register and moves to RESP.
- **RESP**
  - `Rsp_Valid`=1 for one cycle, with `Rsp_Id` set to the latched ID.
  - `rr_ptr` ← (ID+1) mod NUM_REQ.
  - Go to IDLE.
- **Register stability:** `Fpu_A`/`Fpu_B`/`Fpu_Op` hold their values from START through RESP. Requesters may change or drop `Req_*` after their handshake.
- **Ready rule:** `Req_Ready` is 0 in every state except IDLE. A requester holding `Req_Valid` stays pending and is not lost.
- **Back-to-back:** a new grant is possible in the IDLE cycle immediately after RESP.

## Timing
- **Reset values** (on `Reset_n` low, asynchronous, any state including mid-operation):
  - state IDLE; `rr_ptr`=0; counter=0.
  - `Fpu_Start`=0, `Fpu_A`/`Fpu_B`=0, `Fpu_Op`=00.
  - `Rsp_Valid`=0, `Rsp_Id`=0, `Rsp_Result`=0, `Rsp_Error`=0, `Busy`=0.
  - `Req_Ready`=0 while reset is asserted.
- **Reset mid-operation:** the in-flight operation is dropped with no response. A stale `Fpu_Done` after reset release is ignored in IDLE.
- **Latency:** handshake edge at cycle 0; `Fpu_Start` high in cycles 1..`START_CYCLES`; earliest Done sample at cycle `START_CYCLES`+2; `Rsp_Valid` the cycle after Done is sampled. Minimum handshake-to-response is `START_CYCLES`+3 cycles.
- **Simultaneous requests:** only the round-robin winner is readied. A requester that was just served has lowest priority on the next grant.

## Configuration
- **Macro `FPU_ARB_TIMEOUT_EN` defined:**
  - The counter runs in WAIT.
  - If `TIMEOUT` cycles elapse without a qualified `Fpu_Done`, go to RESP with `Rsp_Error`=1 and `Rsp_Result`=0.
  - `Rsp_Error` is meaningful only while `Rsp_Valid`=1; otherwise it is 0.
- **Macro undefined:**
  - WAIT lasts indefinitely until Done.
  - `Rsp_Error` is constant 0 and no timeout logic is synthesized.

## Test plan
- **Single request:** req 0 with add 0x3FC00000 + 0x3FC00000 (1.5 + 1.5); model FPU asserts Done 10 cycles after start falls -> one `Rsp_Valid` pulse, `Rsp_Id`=0, `Rsp_Result`=0x40400000; `Fpu_Start` high exactly 2 cycles.
- **Simultaneous requests:** reqs 1 and 3 valid in the same cycle after reset -> req 1 granted first, req 3 second. Responses: mul 2.0×4.0 gives 0x41000000 with ID 1, then div 1.0/4.0 gives 0x3E800000 with ID 3.
- **Fairness:** all 4 reqs held valid continuously -> grant order 0,1,2,3,0; no requester is ever readied twice before all others have been readied once.
- **Stale Done:** `Fpu_Done` held high through START and the first WAIT cycle -> not sampled until the second WAIT cycle; response appears at the earliest at `START_CYCLES`+3 cycles after the handshake.
- **Reset mid-operation:** `Reset_n` pulsed low during WAIT -> all outputs take reset values immediately; no `Rsp_Valid` for the dropped operation; next grant goes to the lowest valid index.
- **Timeout** (macro defined, `TIMEOUT`=64): FPU never asserts Done -> 64 WAIT cycles, then `Rsp_Valid`=1, `Rsp_Error`=1, `Rsp_Result`=0, return to IDLE.
